// File: rtl/cpu_pkg.sv
// Shared state encoding, instruction field codes and mux encodings for the
// RISC sequencing controller.
package cpu_pkg;

   typedef enum logic [4:0] {
      RST  = 5'd0,
      IF1  = 5'd1,
      IF2  = 5'd2,
      UPC  = 5'd3,
      DEC  = 5'd4,
      WIMM = 5'd5,
      GETA = 5'd6,
      GETB = 5'd7,
      EXEC = 5'd8,
      CMPS = 5'd9,
      WRC  = 5'd10,
      ADDR = 5'd11,
      LDRD = 5'd12,
      LDWB = 5'd13,
      STWR = 5'd14,
      HALT = 5'd15
   } state_t;

   localparam logic [2:0] OPC_MOV  = 3'b110;
   localparam logic [2:0] OPC_ALU  = 3'b101;
   localparam logic [2:0] OPC_LDR  = 3'b011;
   localparam logic [2:0] OPC_STR  = 3'b100;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] OP_MOV_SH  = 2'b00;
   localparam logic [1:0] OP_MOV_IMM = 2'b10;
   localparam logic [1:0] OP_ADD     = 2'b00;
   localparam logic [1:0] OP_CMP     = 2'b01;
   localparam logic [1:0] OP_AND     = 2'b10;
   localparam logic [1:0] OP_MVN     = 2'b11;
   localparam logic [1:0] OP_MEM     = 2'b00;

   localparam logic [2:0] NSEL_RN = 3'b001;
   localparam logic [2:0] NSEL_RD = 3'b010;
   localparam logic [2:0] NSEL_RM = 3'b100;

   localparam logic [1:0] VSEL_C     = 2'b00;
   localparam logic [1:0] VSEL_IMM   = 2'b01;
   localparam logic [1:0] VSEL_PC    = 2'b10;
   localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones once reached.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/cpu_controller.sv
// Moore sequencer for the RISC datapath: fetch, decode, execute, writeback,
// plus sticky illegal-opcode flag and a retired-instruction counter.
module cpu_controller
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       opcode,
   input  logic [1:0]       op,
   output logic             reset_pc,
   output logic             loadpc,
   output logic             msel,
   output logic             mwrite,
   output logic             loadir,
   output logic [2:0]       nsel,
   output logic [1:0]       vsel,
   output logic             write,
   output logic             loada,
   output logic             loadb,
   output logic             asel,
   output logic             bsel,
   output logic             loadc,
   output logic             loads,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] instr_count,
   output logic [4:0]       state_dbg
);

   state_t state, state_next;
   logic   set_illegal;
   logic   count_inc;
   logic   is_ldr, is_str, is_cmp, is_mem, a_zero;

   assign is_ldr = (opcode == OPC_LDR) && (op == OP_MEM);
   assign is_str = (opcode == OPC_STR) && (op == OP_MEM);
   assign is_cmp = (opcode == OPC_ALU) && (op == OP_CMP);
   assign is_mem = is_ldr || is_str;
   // MOV shift and MVN pass B through the ALU with A forced to zero
   assign a_zero = ((opcode == OPC_MOV) && (op == OP_MOV_SH)) ||
                   ((opcode == OPC_ALU) && (op == OP_MVN));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= RST;
         illegal <= 1'b0;
      end else begin
         state <= state_next;
         if (set_illegal) illegal <= 1'b1;
      end
   end

   always_comb begin
      state_next  = state;
      set_illegal = 1'b0;
      reset_pc    = 1'b0;
      loadpc      = 1'b0;
      msel        = 1'b0;
      mwrite      = 1'b0;
      loadir      = 1'b0;
      nsel        = 3'b000;
      vsel        = VSEL_C;
      write       = 1'b0;
      loada       = 1'b0;
      loadb       = 1'b0;
      asel        = 1'b0;
      bsel        = 1'b0;
      loadc       = 1'b0;
      loads       = 1'b0;
      halted      = 1'b0;
      case (state)
         RST: begin
            reset_pc   = 1'b1;
            loadpc     = 1'b1;
            state_next = IF1;
         end
         IF1: state_next = IF2;
         IF2: begin
            loadir     = 1'b1;
            state_next = UPC;
         end
         UPC: begin
            loadpc     = 1'b1;
            state_next = DEC;
         end
         DEC: begin
            if (opcode == OPC_HALT) begin
               state_next = HALT;
            end else begin
               case ({opcode, op})
                  {OPC_MOV, OP_MOV_IMM}: state_next = WIMM;
                  {OPC_MOV, OP_MOV_SH}:  state_next = GETB;
                  {OPC_ALU, OP_ADD},
                  {OPC_ALU, OP_CMP},
                  {OPC_ALU, OP_AND}:     state_next = GETA;
                  {OPC_ALU, OP_MVN}:     state_next = GETB;
                  {OPC_LDR, OP_MEM},
                  {OPC_STR, OP_MEM}:     state_next = GETA;
                  default: begin
                     state_next  = HALT;
                     set_illegal = 1'b1;
                  end
               endcase
            end
         end
         WIMM: begin
            nsel       = NSEL_RN;
            vsel       = VSEL_IMM;
            write      = 1'b1;
            state_next = IF1;
         end
         GETA: begin
            nsel       = NSEL_RN;
            loada      = 1'b1;
            state_next = is_mem ? ADDR : GETB;
         end
         GETB: begin
            // a store reads Rd as the data to be written to memory
            nsel  = is_str ? NSEL_RD : NSEL_RM;
            loadb = 1'b1;
            if (is_str)      state_next = STWR;
            else if (is_cmp) state_next = CMPS;
            else             state_next = EXEC;
         end
         EXEC: begin
            asel       = a_zero;
            loadc      = 1'b1;
            state_next = WRC;
         end
         CMPS: begin
            loads      = 1'b1;
            state_next = IF1;
         end
         WRC: begin
            nsel       = NSEL_RD;
            vsel       = VSEL_C;
            write      = 1'b1;
            state_next = IF1;
         end
         ADDR: begin
            bsel       = 1'b1;
            loadc      = 1'b1;
            state_next = is_ldr ? LDRD : GETB;
         end
         LDRD: begin
            msel       = 1'b1;
            state_next = LDWB;
         end
         LDWB: begin
            msel       = 1'b1;
            nsel       = NSEL_RD;
            vsel       = VSEL_MDATA;
            write      = 1'b1;
            state_next = IF1;
         end
         STWR: begin
            msel       = 1'b1;
            mwrite     = 1'b1;
            state_next = IF1;
         end
         HALT: begin
            halted     = 1'b1;
            state_next = HALT;
         end
         default: state_next = RST;
      endcase
   end

   assign count_inc = (state_next == IF1) && (state != RST);
   assign state_dbg = state;

   sat_counter #(.CNT_W(CNT_W)) u_count (
      .clk   (clk),
      .reset (reset),
      .inc   (count_inc),
      .count (instr_count)
   );

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: walks each instruction class state by
// state against hand-written strobe vectors.
module tb_cpu_controller;
   import cpu_pkg::*;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [2:0]       opcode;
   logic [1:0]       op;
   logic             reset_pc, loadpc, msel, mwrite, loadir;
   logic [2:0]       nsel;
   logic [1:0]       vsel;
   logic             write, loada, loadb, asel, bsel, loadc, loads;
   logic             halted, illegal;
   logic [CNT_W-1:0] instr_count;
   logic [4:0]       state_dbg;

   int errors = 0;
   int checks = 0;

   // strobe vector: {reset_pc,loadpc,msel,mwrite,loadir}, nsel, vsel,
   // {write,loada,loadb,asel,bsel,loadc,loads,halted}
   localparam logic [17:0] E_RST   = {5'b11000, 3'b000, 2'b00, 8'b00000000};
   localparam logic [17:0] E_IF1   = {5'b00000, 3'b000, 2'b00, 8'b00000000};
   localparam logic [17:0] E_IF2   = {5'b00001, 3'b000, 2'b00, 8'b00000000};
   localparam logic [17:0] E_UPC   = {5'b01000, 3'b000, 2'b00, 8'b00000000};
   localparam logic [17:0] E_DEC   = {5'b00000, 3'b000, 2'b00, 8'b00000000};
   localparam logic [17:0] E_WIMM  = {5'b00000, 3'b001, 2'b01, 8'b10000000};
   localparam logic [17:0] E_GETA  = {5'b00000, 3'b001, 2'b00, 8'b01000000};
   localparam logic [17:0] E_GETB  = {5'b00000, 3'b100, 2'b00, 8'b00100000};
   localparam logic [17:0] E_GETBS = {5'b00000, 3'b010, 2'b00, 8'b00100000};
   localparam logic [17:0] E_EXEC  = {5'b00000, 3'b000, 2'b00, 8'b00000100};
   localparam logic [17:0] E_EXECZ = {5'b00000, 3'b000, 2'b00, 8'b00010100};
   localparam logic [17:0] E_CMPS  = {5'b00000, 3'b000, 2'b00, 8'b00000010};
   localparam logic [17:0] E_WRC   = {5'b00000, 3'b010, 2'b00, 8'b10000000};
   localparam logic [17:0] E_ADDR  = {5'b00000, 3'b000, 2'b00, 8'b00001100};
   localparam logic [17:0] E_LDRD  = {5'b00100, 3'b000, 2'b00, 8'b00000000};
   localparam logic [17:0] E_LDWB  = {5'b00100, 3'b010, 2'b11, 8'b10000000};
   localparam logic [17:0] E_STWR  = {5'b00110, 3'b000, 2'b00, 8'b00000000};
   localparam logic [17:0] E_HALT  = {5'b00000, 3'b000, 2'b00, 8'b00000001};

   logic [17:0] strobes;
   assign strobes = {reset_pc, loadpc, msel, mwrite, loadir, nsel, vsel,
                     write, loada, loadb, asel, bsel, loadc, loads, halted};

   cpu_controller #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .op          (op),
      .reset_pc    (reset_pc),
      .loadpc      (loadpc),
      .msel        (msel),
      .mwrite      (mwrite),
      .loadir      (loadir),
      .nsel        (nsel),
      .vsel        (vsel),
      .write       (write),
      .loada       (loada),
      .loadb       (loadb),
      .asel        (asel),
      .bsel        (bsel),
      .loadc       (loadc),
      .loads       (loads),
      .halted      (halted),
      .illegal     (illegal),
      .instr_count (instr_count),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // check the current state and strobes, then advance one cycle
   task automatic cyc(input string tag, input logic [4:0] st,
                      input logic [17:0] e);
      check({tag, ".state"}, 32'(state_dbg), 32'(st));
      check({tag, ".strobes"}, 32'(strobes), 32'(e));
      @(negedge clk);
   endtask

   task automatic fetch(input string tag, input logic [2:0] opc,
                        input logic [1:0] o);
      opcode = opc;
      op     = o;
      cyc({tag, ".if1"}, IF1, E_IF1);
      cyc({tag, ".if2"}, IF2, E_IF2);
      cyc({tag, ".upc"}, UPC, E_UPC);
      cyc({tag, ".dec"}, DEC, E_DEC);
   endtask

   task automatic mov_imm(input string tag);
      fetch(tag, 3'b110, 2'b10);
      cyc({tag, ".wimm"}, WIMM, E_WIMM);
   endtask

   initial begin
      reset  = 1'b0;
      opcode = 3'b000;
      op     = 2'b00;
      @(negedge clk);
      cyc("rst0", RST, E_RST);
      check("rst.count", 32'(instr_count), 0);
      check("rst.halted", 32'(halted), 0);
      check("rst.illegal", 32'(illegal), 0);
      reset = 1'b1;
      cyc("rst1", RST, E_RST);

      mov_imm("movi");
      check("movi.count", 32'(instr_count), 1);

      fetch("movs", 3'b110, 2'b00);
      cyc("movs.getb", GETB, E_GETB);
      cyc("movs.exec", EXEC, E_EXECZ);
      cyc("movs.wrc", WRC, E_WRC);

      fetch("cmp", 3'b101, 2'b01);
      cyc("cmp.geta", GETA, E_GETA);
      cyc("cmp.getb", GETB, E_GETB);
      cyc("cmp.cmps", CMPS, E_CMPS);
      check("cmp.count", 32'(instr_count), 3);

      fetch("add", 3'b101, 2'b00);
      cyc("add.geta", GETA, E_GETA);
      cyc("add.getb", GETB, E_GETB);
      cyc("add.exec", EXEC, E_EXEC);
      cyc("add.wrc", WRC, E_WRC);

      fetch("ldr", 3'b011, 2'b00);
      cyc("ldr.geta", GETA, E_GETA);
      cyc("ldr.addr", ADDR, E_ADDR);
      cyc("ldr.ldrd", LDRD, E_LDRD);
      cyc("ldr.ldwb", LDWB, E_LDWB);

      fetch("str", 3'b100, 2'b00);
      cyc("str.geta", GETA, E_GETA);
      cyc("str.addr", ADDR, E_ADDR);
      cyc("str.getb", GETB, E_GETBS);
      cyc("str.stwr", STWR, E_STWR);

      fetch("mvn", 3'b101, 2'b11);
      cyc("mvn.getb", GETB, E_GETB);
      cyc("mvn.exec", EXEC, E_EXECZ);
      cyc("mvn.wrc", WRC, E_WRC);
      check("mvn.count", 32'(instr_count), 7);

      for (int i = 0; i < 8; i++) mov_imm("sat");
      check("sat.count15", 32'(instr_count), 15);
      mov_imm("sat.hold");
      check("sat.hold", 32'(instr_count), 15);

      fetch("halt", 3'b111, 2'b01);
      for (int i = 0; i < 20; i++) cyc("halt.hold", HALT, E_HALT);
      check("halt.illegal", 32'(illegal), 0);
      check("halt.count", 32'(instr_count), 15);

      reset = 1'b0;
      #1;
      check("arst.state", 32'(state_dbg), 32'(RST));
      check("arst.count", 32'(instr_count), 0);
      @(negedge clk);
      reset = 1'b1;
      cyc("ill.rst", RST, E_RST);
      fetch("ill", 3'b010, 2'b11);
      cyc("ill.halt", HALT, E_HALT);
      check("ill.flag", 32'(illegal), 1);
      check("ill.count", 32'(instr_count), 0);

      reset = 1'b0;
      @(negedge clk);
      check("ill.clear", 32'(illegal), 0);
      reset = 1'b1;
      cyc("abort.rst", RST, E_RST);
      fetch("abort", 3'b101, 2'b00);
      cyc("abort.geta", GETA, E_GETA);
      cyc("abort.getb", GETB, E_GETB);
      check("abort.exec", 32'(state_dbg), 32'(EXEC));
      reset = 1'b0;
      #1;
      check("abort.async", 32'(state_dbg), 32'(RST));
      check("abort.strobes", 32'(strobes), 32'(E_RST));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort.nowrite", 32'({write, loadc}), 0);
      end
      check("abort.count", 32'(instr_count), 0);
      check("abort.illegal", 32'(illegal), 0);
      reset = 1'b1;
      cyc("abort.rel", RST, E_RST);
      cyc("abort.if1", IF1, E_IF1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
Moore state machine that sequences the RISC datapath, instruction register, program counter and RAM. It takes opcode/op from the decoder and drives every load, select and write strobe for fetch, decode, execute and writeback. It also tracks halt and illegal-instruction status, plus a retired-instruction count for debug on LEDR/HEX.

Parameters:
CNT_W, 16, width of retired-instruction counter (saturating)

Ports:
clk  in  1  rising-edge clock (board drives ~KEY[0])
reset  in  1  asynchronous, active-low (0 = reset)
opcode  in  3  decoder opcode field, instruction[15:13]
op  in  2  decoder op field, instruction[12:11]
reset_pc  out  1  PC counter clears to 0 when loadpc is also 1
loadpc  out  1  PC register load enable
msel  out  1  RAM address select: 0 = PC, 1 = C[7:0]
mwrite  out  1  RAM write enable
loadir  out  1  instruction register load
nsel  out  3  one-hot register select: 001 = Rn, 010 = Rd, 100 = Rm
vsel  out  2  writeback source: 00 = C, 01 = sximm8, 10 = PC, 11 = mdata
write  out  1  register file write
loada, loadb  out  1 each  A/B register loads
asel  out  1  1 = ALU A input forced to 0
bsel  out  1  1 = ALU B input is sximm5
loadc  out  1  C register load
loads  out  1  status register load
halted  out  1  high in HALT state
illegal  out  1  sticky; set when an undefined opcode/op is decoded
instr_count  out  CNT_W  retired instructions, saturating
state_dbg  out  5  current state encoding

Behaviour:
- All strobes are decoded from the current state only. Every strobe not listed for a state is 0.
- Reset (asynchronous) forces state RST, halted=0, illegal=0, instr_count=0. In RST: reset_pc=1, loadpc=1, all other outputs 0.
- Reset asserted mid-instruction aborts it immediately. No partial write completes after the asynchronous assert.
- First rising edge with reset=1 moves RST -> IF1.
- IF1: msel=0. The RAM registers the read at PC. -> IF2
- IF2: msel=0, loadir=1. -> UPC
- UPC: loadpc=1 (PC+1). -> DEC
- DEC: no strobes. Branches on {opcode,op}:
  - 110_10 MOV imm -> WIMM
  - 110_00 MOV shift -> GETB
  - 101_00 ADD, 101_01 CMP, 101_10 AND -> GETA
  - 101_11 MVN -> GETB
  - 011_00 LDR -> GETA
  - 100_00 STR -> GETA
  - 111_xx -> HALT
  - any other code -> HALT with illegal set.
- WIMM: nsel=001, vsel=01, write=1. -> IF1
- GETA: nsel=001, loada=1. -> ADDR for LDR/STR, otherwise -> GETB.
- GETB: nsel=100, loadb=1 for ALU/MOV. For STR use nsel=010 (Rd).
  - STR -> STWR
  - CMP -> CMPS
  - all others -> EXEC
- EXEC: loadc=1, bsel=0. asel=1 for MOV shift and MVN, else 0. -> WRC
- CMPS: asel=0, bsel=0, loads=1, loadc=0. -> IF1
- WRC: nsel=010, vsel=00, write=1. -> IF1
- ADDR: asel=0, bsel=1, loadc=1 (C = Rn + sximm5).
  - LDR -> LDRD
  - STR -> GETB
- LDRD: msel=1. -> LDWB
- LDWB: msel=1, nsel=010, vsel=11, write=1. -> IF1
- STWR: msel=1, mwrite=1. -> IF1
- HALT: halted=1, no other strobes. Stays until reset.
- Latency, counted in cycles from IF1:
  - MOV imm: 5
  - MOV shift, MVN, CMP: 7
  - ADD, AND, LDR, STR: 8
- instr_count increments by 1 on every transition into IF1 from a state other than RST. It saturates at all-ones. HALT does not count.
- ALUop and shift come directly from the decoder. The controller never drives them.

Decomposition:
- cpu_pkg holds:
  - state enum (RST, IF1, IF2, UPC, DEC, WIMM, GETA, GETB, EXEC, CMPS, WRC, ADDR, LDRD, LDWB, STWR, HALT)
  - opcode/op constants
  - nsel and vsel encodings
- Single module. The next-state and output decode stay in cpu_controller. An optional sub-module sat_counter (CNT_W) implements instr_count.

Test Plan:
- reset=0 for 2 clk, then 1 -> state RST with reset_pc=loadpc=1 throughout. Next edge gives IF1. instr_count=0, halted=0.
- Drive opcode=110, op=10 (MOV R0,#5) -> states IF1,IF2,UPC,DEC,WIMM in 5 cycles. WIMM shows nsel=001, vsel=01, write=1. instr_count becomes 1 on the return to IF1.
- Drive opcode=101, op=01 (CMP) -> sequence GETA,GETB,CMPS. loads=1 only in CMPS, write never asserted. Return to IF1 after 7 cycles.
- Drive opcode=011, op=00 (LDR), then 100/00 (STR):
  - LDR: ADDR has bsel=1, loadc=1. LDRD/LDWB have msel=1. LDWB has vsel=11, write=1.
  - STR: GETB has nsel=010. STWR has msel=1, mwrite=1.
- Drive opcode=111 -> HALT with halted=1, held for 20 cycles with no strobes. Drive opcode=010, op=11 after a fresh reset -> HALT, illegal=1.
- Assert reset during EXEC of an ADD -> state RST asynchronously, write/loadc never asserted afterwards. instr_count=0 and illegal=0 after reset.
